// File: rtl/riscv_core_div_seq_if.sv
// Issue/response bundle between the execute stage and the sequential divider.
// The core drives the i_* signals; the divider drives the o_* signals.
interface riscv_core_div_seq_if #(
  parameter int XLEN = 64
);
  logic            i_div_start;
  logic [1:0]      i_div_op;
  logic            i_div_isword;
  logic [XLEN-1:0] i_div_srcA;
  logic [XLEN-1:0] i_div_srcB;
  logic            i_div_flush;
  logic            o_div_busy;
  logic            o_div_valid;
  logic [XLEN-1:0] o_div_result;

  modport master (
    output i_div_start, i_div_op, i_div_isword, i_div_srcA, i_div_srcB, i_div_flush,
    input  o_div_busy, o_div_valid, o_div_result
  );

  modport slave (
    input  i_div_start, i_div_op, i_div_isword, i_div_srcA, i_div_srcB, i_div_flush,
    output o_div_busy, o_div_valid, o_div_result
  );
endinterface

// File: rtl/riscv_core_div_seq.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms.
// Sequenced IDLE -> PREP -> CALC (N steps) -> FIX -> DONE; all outputs registered.
module riscv_core_div_seq #(
  parameter int XLEN = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  riscv_core_div_seq_if.slave  div_if
);
  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CW-1:0]   C_CNT_FULL = CW'(XLEN-1);
  localparam logic [CW-1:0]   C_CNT_WORD = CW'(31);
  localparam logic [CW-1:0]   C_CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   C_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] C_ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] C_ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] C_MIN_D    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_MIN_W    = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  function automatic logic [XLEN-1:0] fn_word_ext(input logic isw, input logic [XLEN-1:0] v);
    fn_word_ext = isw ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] fn_cond_neg(input logic neg, input logic [XLEN-1:0] v);
    fn_cond_neg = neg ? (C_ZERO - v) : v;
  endfunction

  logic [2:0]      r_state;
  logic [1:0]      r_op;
  logic            r_isword;
  logic [XLEN-1:0] r_src_a;
  logic [XLEN-1:0] r_src_b;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic            r_qneg;
  logic            r_rneg;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_valid;
  logic [XLEN-1:0] r_result;

  logic [2:0]      w_next_state;
  logic            w_signed;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_quo_init;
  logic            w_divz;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_step;
  logic [XLEN-1:0] w_fix_res;
  logic [XLEN-1:0] w_done_res;

  assign div_if.o_div_busy   = r_busy;
  assign div_if.o_div_valid  = r_valid;
  assign div_if.o_div_result = r_result;

  // Operand conditioning and special-case detection, evaluated while in PREP.
  always_comb begin
    w_signed = ~r_op[0];
    if (r_isword) begin
      w_a_ext = w_signed ? {{(XLEN-32){r_src_a[31]}}, r_src_a[31:0]} : {{(XLEN-32){1'b0}}, r_src_a[31:0]};
      w_b_ext = w_signed ? {{(XLEN-32){r_src_b[31]}}, r_src_b[31:0]} : {{(XLEN-32){1'b0}}, r_src_b[31:0]};
    end else begin
      w_a_ext = r_src_a;
      w_b_ext = r_src_b;
    end
    w_a_neg = w_signed & w_a_ext[XLEN-1];
    w_b_neg = w_signed & w_b_ext[XLEN-1];
    w_a_mag = fn_cond_neg(w_a_neg, w_a_ext);
    w_b_mag = fn_cond_neg(w_b_neg, w_b_ext);
    // W ops run 32 steps, so the dividend must start at the top of the shift register.
    w_quo_init = r_isword ? {w_a_mag[31:0], {(XLEN-32){1'b0}}} : w_a_mag;
    w_divz = (w_b_ext == C_ZERO);
    w_ovf  = w_signed & (w_a_ext == (r_isword ? C_MIN_W : C_MIN_D)) & (w_b_ext == C_ONES);
    if (w_divz) begin
      w_spec_res = r_op[1] ? w_a_ext : C_ONES;
    end else begin
      w_spec_res = r_op[1] ? C_ZERO : w_a_ext;
    end
  end

  // One restoring step; the compare is XLEN+1 wide so large unsigned divisors work.
  always_comb begin
    w_shift = {r_rem, r_quo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, r_dvs});
    if (w_ge) begin
      w_rem_step = w_shift[XLEN-1:0] - r_dvs;
    end else begin
      w_rem_step = w_shift[XLEN-1:0];
    end
  end

  // Sign fix-up and final result selection for entry into DONE.
  always_comb begin
    if (r_op[1]) begin
      w_fix_res = fn_cond_neg(r_rneg, r_rem);
    end else begin
      w_fix_res = fn_cond_neg(r_qneg, r_quo);
    end
    if (r_state == S_PREP) begin
      w_done_res = fn_word_ext(r_isword, w_spec_res);
    end else begin
      w_done_res = fn_word_ext(r_isword, w_fix_res);
    end
  end

  // Sequencer next-state decision; flush returns any active state to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (div_if.i_div_start && !div_if.i_div_flush) w_next_state = S_PREP;
        else                                           w_next_state = S_IDLE;
      end
      S_PREP: begin
        if (div_if.i_div_flush)    w_next_state = S_IDLE;
        else if (w_divz || w_ovf)  w_next_state = S_DONE;
        else                       w_next_state = S_CALC;
      end
      S_CALC: begin
        if (div_if.i_div_flush)       w_next_state = S_IDLE;
        else if (r_cnt == C_CNT_ZERO) w_next_state = S_FIX;
        else                          w_next_state = S_CALC;
      end
      S_FIX: begin
        if (div_if.i_div_flush) w_next_state = S_IDLE;
        else                    w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State and registered outputs, derived from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= C_ZERO;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      r_valid <= (w_next_state == S_DONE);
      if (w_next_state == S_DONE) begin
        r_result <= w_done_res;
      end
    end
  end

  // Operand capture and iterative datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= 2'b00;
      r_isword <= 1'b0;
      r_src_a  <= C_ZERO;
      r_src_b  <= C_ZERO;
      r_quo    <= C_ZERO;
      r_rem    <= C_ZERO;
      r_dvs    <= C_ZERO;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_cnt    <= C_CNT_ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (div_if.i_div_start && !div_if.i_div_flush) begin
            r_op     <= div_if.i_div_op;
            r_isword <= div_if.i_div_isword;
            r_src_a  <= div_if.i_div_srcA;
            r_src_b  <= div_if.i_div_srcB;
          end
        end
        S_PREP: begin
          r_quo  <= w_quo_init;
          r_rem  <= C_ZERO;
          r_dvs  <= w_b_mag;
          r_qneg <= w_a_neg ^ w_b_neg;
          r_rneg <= w_a_neg;
          r_cnt  <= r_isword ? C_CNT_WORD : C_CNT_FULL;
        end
        S_CALC: begin
          r_rem <= w_rem_step;
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - C_CNT_ONE;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_core_div_seq.sv
// Self-checking bench for riscv_core_div_seq: directed plan cases, randomized ops
// against an arithmetic reference model, flush, busy-start and reset behaviour.
module tb_riscv_core_div_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] last_res;

  riscv_core_div_seq_if #(.XLEN(64)) div_if ();

  riscv_core_div_seq #(.XLEN(64)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .div_if  (div_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics with plain integer arithmetic.
  function automatic void ref_model(input logic [1:0] op, input logic isw,
                                    input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output int lat);
    bit is_signed;
    bit want_rem;
    int sa, sb;
    longint la, lb;
    logic [31:0] q32, r32;
    logic [63:0] q64, r64;
    is_signed = (op == 2'b00) || (op == 2'b10);
    want_rem  = (op == 2'b10) || (op == 2'b11);
    if (isw) begin
      sa = a[31:0];
      sb = b[31:0];
      if (b[31:0] == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a[31:0]; lat = 2;
      end else if (is_signed && sa == 32'sh8000_0000 && sb == -32'sd1) begin
        q32 = a[31:0]; r32 = 32'd0; lat = 2;
      end else begin
        lat = 35;
        if (is_signed) begin
          q32 = 32'(sa / sb); r32 = 32'(sa % sb);
        end else begin
          q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
        end
      end
      res = want_rem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end else begin
      la = a;
      lb = b;
      if (b == 64'd0) begin
        q64 = 64'hFFFF_FFFF_FFFF_FFFF; r64 = a; lat = 2;
      end else if (is_signed && la == 64'sh8000_0000_0000_0000 && lb == -64'sd1) begin
        q64 = a; r64 = 64'd0; lat = 2;
      end else begin
        lat = 67;
        if (is_signed) begin
          q64 = 64'(la / lb); r64 = 64'(la % lb);
        end else begin
          q64 = a / b; r64 = a % b;
        end
      end
      res = want_rem ? r64 : q64;
    end
  endfunction

  // Issue one op; optionally pulse a competing start during cycle 'intrude'.
  task automatic run_op(input string tag, input logic [1:0] op, input logic isw,
                        input logic [63:0] a, input logic [63:0] b, input int intrude);
    logic [63:0] exp_res;
    logic [63:0] got;
    int exp_lat;
    int lat;
    bit busy_ok;
    bit busy_at_done;
    ref_model(op, isw, a, b, exp_res, exp_lat);
    div_if.i_div_op     = op;
    div_if.i_div_isword = isw;
    div_if.i_div_srcA   = a;
    div_if.i_div_srcB   = b;
    div_if.i_div_start  = 1'b1;
    @(posedge clk);
    #1;
    div_if.i_div_start  = 1'b0;
    div_if.i_div_op     = 2'($urandom);
    div_if.i_div_isword = 1'($urandom);
    div_if.i_div_srcA   = {$urandom, $urandom};
    div_if.i_div_srcB   = {$urandom, $urandom};
    lat = 0;
    got = 64'd0;
    busy_ok = 1'b1;
    busy_at_done = 1'b0;
    for (int c = 1; c <= 100 && lat == 0; c++) begin
      @(negedge clk);
      if (div_if.o_div_valid === 1'b1) begin
        lat = c;
        got = div_if.o_div_result;
        busy_at_done = div_if.o_div_busy;
      end else if (div_if.o_div_busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      div_if.i_div_start = (c == intrude);
    end
    div_if.i_div_start = 1'b0;
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".result"}, got, exp_res);
    chk({tag, ".busy_held"}, {63'd0, busy_ok & busy_at_done}, 64'd1);
    @(negedge clk);
    chk({tag, ".valid_pulse"}, {63'd0, div_if.o_div_valid}, 64'd0);
    chk({tag, ".busy_drop"}, {63'd0, div_if.o_div_busy}, 64'd0);
    last_res = exp_res;
  endtask

  initial begin
    int vcount;
    logic [63:0] ra, rb;
    logic [1:0]  rop;
    logic        risw;

    rst_n = 1'b0;
    div_if.i_div_start  = 1'b0;
    div_if.i_div_op     = 2'b00;
    div_if.i_div_isword = 1'b0;
    div_if.i_div_srcA   = 64'd0;
    div_if.i_div_srcB   = 64'd0;
    div_if.i_div_flush  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.busy", {63'd0, div_if.o_div_busy}, 64'd0);
    chk("reset.valid", {63'd0, div_if.o_div_valid}, 64'd0);
    chk("reset.result", div_if.o_div_result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_100_7", 2'b00, 1'b0, 64'd100, 64'd7, 0);
    chk("div_100_7.value", last_res, 64'h0000_0000_0000_000E);
    run_op("rem_100_7", 2'b10, 1'b0, 64'd100, 64'd7, 0);
    run_op("divw_m7_2", 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    chk("divw_m7_2.value", last_res, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("remw_m7_2", 2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
    run_op("divuw_big", 2'b01, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 0);
    chk("divuw_big.value", last_res, 64'hFFFF_FFFF_8000_0000);
    run_op("divu_big", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("div_by0", 2'b00, 1'b0, 64'h1234, 64'd0, 0);
    run_op("remu_by0", 2'b11, 1'b0, 64'h1234, 64'd0, 0);
    run_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("remw_ovf", 2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    run_op("busy_start", 2'b00, 1'b0, 64'd1000, 64'd7, 10);

    for (int i = 0; i < 24; i++) begin
      rop  = 2'($urandom_range(0, 3));
      risw = 1'($urandom_range(0, 1));
      ra   = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       rb = 64'd0;
        1: begin rb = 64'hFFFF_FFFF_FFFF_FFFF; ra = risw ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000; end
        2:       rb = 64'($urandom_range(1, 20));
        3:       rb = {32'd0, $urandom};
        4:       rb = -64'($urandom_range(1, 1000));
        default: rb = {$urandom, $urandom};
      endcase
      run_op($sformatf("rand%0d", i), rop, risw, ra, rb, 0);
    end

    // Flush during cycle 20 of a DIV: idle next cycle, no pulse, result kept.
    vcount = 0;
    div_if.i_div_op = 2'b00; div_if.i_div_isword = 1'b0;
    div_if.i_div_srcA = 64'd5000; div_if.i_div_srcB = 64'd3;
    div_if.i_div_start = 1'b1;
    @(posedge clk);
    #1;
    div_if.i_div_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (div_if.o_div_valid === 1'b1) vcount++;
      div_if.i_div_flush = (c == 20);
    end
    @(negedge clk);
    div_if.i_div_flush = 1'b0;
    chk("flush.busy", {63'd0, div_if.o_div_busy}, 64'd0);
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (div_if.o_div_valid === 1'b1) vcount++;
    end
    chk("flush.no_valid", 64'(vcount), 64'd0);
    chk("flush.result_kept", div_if.o_div_result, last_res);

    div_if.i_div_start = 1'b1;
    div_if.i_div_flush = 1'b1;
    @(negedge clk);
    div_if.i_div_start = 1'b0;
    div_if.i_div_flush = 1'b0;
    chk("flush_start.busy", {63'd0, div_if.o_div_busy}, 64'd0);
    @(negedge clk);
    chk("flush_start.busy2", {63'd0, div_if.o_div_busy}, 64'd0);
    chk("flush_start.valid", {63'd0, div_if.o_div_valid}, 64'd0);

    // Asynchronous reset in the middle of CALC.
    div_if.i_div_srcA = 64'd77777; div_if.i_div_srcB = 64'd11;
    div_if.i_div_start = 1'b1;
    @(posedge clk);
    #1;
    div_if.i_div_start = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_reset.busy", {63'd0, div_if.o_div_busy}, 64'd0);
    chk("mid_reset.valid", {63'd0, div_if.o_div_valid}, 64'd0);
    chk("mid_reset.result", div_if.o_div_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_reset_9_3", 2'b00, 1'b0, 64'd9, 64'd3, 0);
    chk("after_reset_9_3.value", last_res, 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_core_div_seq.md
Name: riscv_core_div_seq

Overview:
- Iterative radix-2 divide unit with its own sequencing FSM for the RV64M DIV/DIVU/REM/REMU instructions and their W variants.
- Sits in the execute stage beside the single-cycle integer ALU.
- The core issues one operation with a start pulse and holds the pipeline while o_div_busy is high.
- The result is returned with a single-cycle valid pulse; a flush aborts an in-flight operation.

Parameters:
- XLEN, 64, operand/result width; N = XLEN iterations for full-width ops, 32 for W ops.

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_div_start  in  1  start request; accepted only in IDLE
- i_div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_div_isword  in  1  1 = W variant (32-bit operation, sign-extended result)
- i_div_srcA  in  XLEN  dividend
- i_div_srcB  in  XLEN  divisor
- i_div_flush  in  1  abort current operation
- o_div_busy  out  1  operation in progress (PREP/CALC/FIX/DONE)
- o_div_valid  out  1  result valid, one-cycle pulse
- o_div_result  out  XLEN  quotient or remainder

Behaviour:
- Reset: the clock and reset are fixed as one clock (i_clk) and an asynchronous, active-low reset (i_rst_n).
  - Asserting i_rst_n low forces state=IDLE, o_div_busy=0, o_div_valid=0, o_div_result=0, and clears all internal registers.
  - Reset asserted mid-operation discards the operation; no valid pulse is produced.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - Start acceptance: on i_div_start=1 with i_div_flush=0, latch op, isword, srcA and srcB, then go to PREP.
  - Operand isolation: inputs are don't-care after acceptance.
- PREP, operand conditioning:
  - Word ops: take bits [31:0] of each source, sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed ops: record the quotient sign (signA XOR signB) and the remainder sign (signA), then convert both operands to magnitudes.
  - Iteration counter: load with N-1.
- PREP, special cases (decided in PREP; go straight to DONE with no CALC/FIX):
  - Divide by zero (operand-width divisor == 0): quotient = all ones; remainder = dividend (operand width, pre-magnitude).
  - Signed overflow (dividend = most-negative value of operand width, divisor = -1): quotient = dividend; remainder = 0.
  - Otherwise go to CALC.
- CALC, one restoring step per cycle:
  - Shift {rem,quo} left by 1 and subtract the divisor magnitude from rem.
  - If the difference is non-negative, keep it and set quo[0]=1; else restore and set quo[0]=0.
  - Decrement the counter; go to FIX after the step taken with counter==0 (exactly N CALC cycles).
- FIX:
  - Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Select the quotient or the remainder per op and go to DONE.
- DONE:
  - o_div_valid=1 for exactly this cycle and o_div_result updated.
  - Next state IDLE unconditionally.
  - o_div_busy=1 in DONE so the core cannot restart in the same cycle.
- Result width: W ops return the 32-bit result sign-extended from bit 31 to XLEN, including DIVUW and REMUW.
- o_div_result holds its last value until the next DONE; it is not cleared on flush.
- Latency, with start sampled at edge 0:
  - Normal op: valid during cycle N+3 (67 for 64-bit, 35 for W).
  - Special case: valid during cycle 2.
  - Next start is accepted at cycle N+4 or later.
- o_div_busy=0 only in IDLE.
- i_div_start while busy is ignored and not queued.
- Flush:
  - i_div_flush=1 in any non-IDLE state: next state IDLE, no valid pulse.
  - Flush in the DONE cycle does not suppress the valid already being driven.
  - Flush and start in the same IDLE cycle: flush wins, start is dropped.
- Arithmetic: the datapath is XLEN+1 bits wide for the subtract so DIVU with a large divisor is correct.

Test Plan:
- DIV 100/7, then REM 100/7 (op=10) → 0x000000000000000E at cycle 67, then 0x0000000000000002; busy high cycles 1..67; valid for exactly 1 cycle.
- DIVW srcA=0xFFFFFFFFFFFFFFF9 (-7), srcB=2 → 0xFFFFFFFFFFFFFFFD at cycle 35; REMW same operands → 0xFFFFFFFFFFFFFFFF.
- DIVUW srcA=0x0000000080000000, srcB=1 → 0xFFFFFFFF80000000; DIVU srcA=0xFFFFFFFFFFFFFFFF, srcB=0xFFFFFFFFFFFFFFFE → 1.
- Divide by zero, DIV 0x1234 by 0 → 0xFFFFFFFFFFFFFFFF at cycle 2; REMU 0x1234 by 0 → 0x1234; overflow DIV 0x8000000000000000 by -1 → 0x8000000000000000, REM → 0.
- Flush at cycle 20 of a DIV → IDLE at cycle 21, no valid pulse, o_div_result unchanged; flush+start in the same IDLE cycle → stays IDLE.
- Start asserted at cycle 10 while busy → ignored, original result unchanged; i_rst_n pulsed low mid-CALC → busy/valid/result 0 immediately, and a fresh DIV 9/3 afterwards → 3.
